// File: rtl/pgm_pkg.sv
// Shared definitions for the PGM generator: RAM geometry, packet header codes
// and read-side FSM encodings.
package pgm_pkg;

  localparam logic [1:0] HDR_HEAD = 2'b01;
  localparam logic [1:0] HDR_BODY = 2'b11;
  localparam logic [1:0] HDR_TAIL = 2'b10;

  localparam int RAM_AW = 7;
  localparam int RAM_DW = 144;
  localparam int PKT_W  = 134;
  localparam int PHV_W  = 1024;
  localparam int SEQ_W  = 32;

  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_ARM  = 2'd1,
    RD_SEND = 2'd2,
    RD_GAP  = 2'd3
  } rd_state_e;

  function automatic logic [1:0] pkt_hdr(input logic [PKT_W-1:0] w);
    return w[PKT_W-1 -: 2];
  endfunction

endpackage

// File: rtl/pgm_rd_gen_if.sv
// Downstream packet/PHV bus of the PGM read generator, including the
// backpressure flags returned by the next module.
interface pgm_rd_gen_if;
  import pgm_pkg::*;

  logic [PKT_W-1:0] out_rd_data;
  logic             out_rd_data_wr;
  logic             out_rd_valid;
  logic             out_rd_valid_wr;
  logic [PHV_W-1:0] out_rd_phv;
  logic             out_rd_phv_wr;
  logic             in_rd_alf;
  logic             in_rd_phv_alf;

  modport master (
    output out_rd_data, out_rd_data_wr, out_rd_valid, out_rd_valid_wr,
           out_rd_phv, out_rd_phv_wr,
    input  in_rd_alf, in_rd_phv_alf
  );

  modport slave (
    input  out_rd_data, out_rd_data_wr, out_rd_valid, out_rd_valid_wr,
           out_rd_phv, out_rd_phv_wr,
    output in_rd_alf, in_rd_phv_alf
  );

endinterface

// File: rtl/pgm_token_bucket.sv
// Token bucket rate limiter: refills by INC per enabled cycle up to MAX and
// is drained by COST on a consume cycle; held empty while disabled.
module pgm_token_bucket #(
  parameter logic [15:0] INC  = 16'd1,
  parameter logic [15:0] MAX  = 16'd4096,
  parameter logic [15:0] COST = 16'd256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        consume,
  output logic [15:0] tokens,
  output logic        ok
);

  function automatic logic [15:0] sat_add(input logic [15:0] t);
    logic [16:0] s;
    s = {1'b0, t} + {1'b0, INC};
    return (s > {1'b0, MAX}) ? MAX : s[15:0];
  endfunction

  logic [15:0] tokens_nxt;

  always_comb begin
    tokens_nxt = '0;
    if (en) begin
      tokens_nxt = sat_add(tokens);
      if (consume && (tokens_nxt >= COST)) tokens_nxt = tokens_nxt - COST;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) tokens <= '0;
    else        tokens <= tokens_nxt;
  end

  assign ok = (tokens >= COST);

endmodule

// File: rtl/pgm_rd_gen.sv
// PGM read generator: replays the stored template packet from PGM_RAM while
// replay is enabled, one copy per token-bucket grant.
module pgm_rd_gen
  import pgm_pkg::*;
#(
  parameter logic [15:0] TOKEN_INC  = 16'd1,
  parameter logic [15:0] BUCKET_MAX = 16'd4096,
  parameter logic [15:0] PKT_COST   = 16'd256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pgm_bypass_flag,
  input  logic              pgm_sent_start_flag,
  input  logic              pgm_sent_finish_flag,
  output logic              rd2ram_rd_en,
  output logic [RAM_AW-1:0] rd2ram_addr,
  input  logic [RAM_DW-1:0] ram2rd_rdata,
  pgm_rd_gen_if.master      rd_if,
  output logic [31:0]       out_rd_pkt_cnt,
  output logic [15:0]       out_rd_err_cnt
);

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  rd_state_e         state, state_nxt;
  logic [RAM_AW:0]   addr_q, addr_nxt;   // MSB flags that the last address was issued
  logic              consume, tb_ok, start_ok, stop_req, dn_ready;
  logic [15:0]       unused_tokens;
  logic              unused_rdata;
  logic [SEQ_W-1:0]  seq;

  logic              vld_p0;
  logic [RAM_AW-1:0] addr_p0;
  logic [PKT_W-1:0]  word_p0;
  logic              emit_p0, tail_p0, trunc_p0, last_p0;

  assign unused_rdata = ^ram2rd_rdata[RAM_DW-1:PKT_W];

  assign start_ok = pgm_sent_start_flag & ~pgm_sent_finish_flag & ~pgm_bypass_flag;
  assign stop_req = pgm_sent_finish_flag | ~pgm_sent_start_flag | pgm_bypass_flag;
  assign dn_ready = tb_ok & ~rd_if.in_rd_alf & ~rd_if.in_rd_phv_alf;

  pgm_token_bucket #(
    .INC  (TOKEN_INC),
    .MAX  (BUCKET_MAX),
    .COST (PKT_COST)
  ) u_bucket (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (state != RD_IDLE),
    .consume (consume),
    .tokens  (unused_tokens),
    .ok      (tb_ok)
  );

  always_comb begin
    state_nxt    = state;
    addr_nxt     = addr_q;
    rd2ram_rd_en = 1'b0;
    rd2ram_addr  = '0;
    consume      = 1'b0;
    case (state)
      RD_IDLE: if (start_ok) state_nxt = RD_ARM;
      RD_ARM: begin
        if (stop_req) begin
          state_nxt = RD_IDLE;
        end else if (dn_ready) begin
          rd2ram_rd_en = 1'b1;
          addr_nxt     = (RAM_AW+1)'(1);
          consume      = 1'b1;
          state_nxt    = RD_SEND;
        end
      end
      RD_SEND: begin
        rd2ram_rd_en = ~addr_q[RAM_AW];
        rd2ram_addr  = addr_q[RAM_AW-1:0];
        if (!addr_q[RAM_AW]) addr_nxt = addr_q + 1'b1;
        if (last_p0) state_nxt = RD_GAP;
      end
      RD_GAP:  state_nxt = stop_req ? RD_IDLE : RD_ARM;
      default: state_nxt = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= RD_IDLE;
      addr_q <= '0;
    end else begin
      state  <= state_nxt;
      addr_q <= addr_nxt;
    end
  end

  // p0: RAM read data returns; words arriving outside SEND are discarded
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p0  <= 1'b0;
      addr_p0 <= '0;
    end else begin
      vld_p0  <= rd2ram_rd_en;
      addr_p0 <= rd2ram_addr;
    end
  end

  assign word_p0  = ram2rd_rdata[PKT_W-1:0];
  assign emit_p0  = vld_p0 && (state == RD_SEND);
  assign tail_p0  = (pkt_hdr(word_p0) == HDR_TAIL);
  assign trunc_p0 = emit_p0 && !tail_p0 && (addr_p0 == '1);
  assign last_p0  = emit_p0 && (tail_p0 || (addr_p0 == '1));

  // p1: output register, status pulses and counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_if.out_rd_data     <= '0;
      rd_if.out_rd_data_wr  <= 1'b0;
      rd_if.out_rd_phv      <= '0;
      rd_if.out_rd_phv_wr   <= 1'b0;
      rd_if.out_rd_valid    <= 1'b0;
      rd_if.out_rd_valid_wr <= 1'b0;
      out_rd_pkt_cnt        <= '0;
      out_rd_err_cnt        <= '0;
      seq                   <= '0;
    end else begin
      rd_if.out_rd_data_wr  <= emit_p0;
      rd_if.out_rd_data     <= !emit_p0 ? '0 :
                               trunc_p0 ? {HDR_TAIL, word_p0[PKT_W-3:0]} : word_p0;
      rd_if.out_rd_phv_wr   <= emit_p0 && (pkt_hdr(word_p0) == HDR_HEAD);
      rd_if.out_rd_phv      <= (emit_p0 && (pkt_hdr(word_p0) == HDR_HEAD)) ?
                               {{(PHV_W-SEQ_W){1'b0}}, seq} : '0;
      rd_if.out_rd_valid    <= (state == RD_GAP);
      rd_if.out_rd_valid_wr <= (state == RD_GAP);
      if ((state == RD_IDLE) && start_ok) begin
        out_rd_pkt_cnt <= '0;
        out_rd_err_cnt <= '0;
        seq            <= '0;
      end else begin
        if (state == RD_GAP) begin
          out_rd_pkt_cnt <= sat_inc32(out_rd_pkt_cnt);
          seq            <= seq + 1'b1;
        end
        if (trunc_p0) out_rd_err_cnt <= sat_inc16(out_rd_err_cnt);
      end
    end
  end

endmodule

// File: tb/tb_pgm_rd_gen.sv
// Directed bench for pgm_rd_gen: a fast-refill instance (INC=256) and a
// slow-refill instance (INC=1) share one behavioural PGM_RAM image.
`timescale 1ns/1ps
module tb_pgm_rd_gen;
  import pgm_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         byp_f, start_f, fin_f, byp_s, start_s, fin_s;
  logic         rd_en_f, rd_en_s;
  logic [6:0]   addr_f, addr_s;
  logic [143:0] rdata_f, rdata_s;
  logic [31:0]  pkt_f, pkt_s;
  logic [15:0]  err_f, err_s;
  logic [143:0] mem [0:127];

  int n_cmp = 0;
  int n_bad = 0;

  pgm_rd_gen_if if_f();
  pgm_rd_gen_if if_s();

  pgm_rd_gen #(.TOKEN_INC(16'd256), .BUCKET_MAX(16'd4096), .PKT_COST(16'd256)) dut_f (
    .clk(clk), .rst_n(rst_n), .pgm_bypass_flag(byp_f), .pgm_sent_start_flag(start_f),
    .pgm_sent_finish_flag(fin_f), .rd2ram_rd_en(rd_en_f), .rd2ram_addr(addr_f),
    .ram2rd_rdata(rdata_f), .rd_if(if_f), .out_rd_pkt_cnt(pkt_f), .out_rd_err_cnt(err_f));

  pgm_rd_gen #(.TOKEN_INC(16'd1), .BUCKET_MAX(16'd4096), .PKT_COST(16'd256)) dut_s (
    .clk(clk), .rst_n(rst_n), .pgm_bypass_flag(byp_s), .pgm_sent_start_flag(start_s),
    .pgm_sent_finish_flag(fin_s), .rd2ram_rd_en(rd_en_s), .rd2ram_addr(addr_s),
    .ram2rd_rdata(rdata_s), .rd_if(if_s), .out_rd_pkt_cnt(pkt_s), .out_rd_err_cnt(err_s));

  always @(posedge clk) begin
    if (rd_en_f) rdata_f <= mem[addr_f];
    if (rd_en_s) rdata_s <= mem[addr_s];
  end

  function automatic logic [143:0] mkword(input logic [1:0] hdr, input int idx);
    return {10'h2A5, hdr, 100'h0, 32'hC0DE0000 + 32'(idx)};
  endfunction

  function automatic logic [1:0] exp_hdr(input int idx, input int tail);
    if (idx == 0) return HDR_HEAD;
    if (idx == tail) return HDR_TAIL;
    return HDR_BODY;
  endfunction

  // tail < 0 gives a template with no tail word; words past the tail are heads
  task automatic load_template(input int tail);
    for (int i = 0; i < 128; i++)
      mem[i] = (tail >= 0 && i > tail) ? mkword(HDR_HEAD, i) : mkword(exp_hdr(i, tail), i);
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_cmp++; if (if_f.out_rd_data_wr !== 1'b0) begin n_bad++; $display("FAIL rst_data_wr: got %b want 0", if_f.out_rd_data_wr); end
    n_cmp++; if (if_f.out_rd_data !== '0) begin n_bad++; $display("FAIL rst_data: got %h want 0", if_f.out_rd_data); end
    n_cmp++; if (if_f.out_rd_valid !== 1'b0 || if_f.out_rd_valid_wr !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b%b want 00", if_f.out_rd_valid, if_f.out_rd_valid_wr); end
    n_cmp++; if (if_f.out_rd_phv_wr !== 1'b0 || if_f.out_rd_phv !== '0) begin n_bad++; $display("FAIL rst_phv: got wr=%b phv_lo=%h want 0", if_f.out_rd_phv_wr, if_f.out_rd_phv[31:0]); end
    n_cmp++; if (pkt_f !== 32'd0 || err_f !== 16'd0) begin n_bad++; $display("FAIL rst_cnt: got pkt=%0d err=%0d want 0", pkt_f, err_f); end
    n_cmp++; if (rd_en_f !== 1'b0 || rd_en_s !== 1'b0) begin n_bad++; $display("FAIL rst_rd_en: got %b%b want 00", rd_en_f, rd_en_s); end
    n_cmp++; if (dut_f.state !== RD_IDLE) begin n_bad++; $display("FAIL rst_state: got %0d want IDLE", dut_f.state); end
  endtask

  task automatic test_back_to_back();
    logic [143:0]  w;
    logic [1023:0] ephv;
    logic [1:0]    eh;
    int widx, heads, last_head, tail_cyc, nvalid;
    load_template(2);
    widx = 0; heads = 0; last_head = -1; tail_cyc = -10; nvalid = 0;
    @(negedge clk); start_f = 1'b1;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (if_f.out_rd_data_wr) begin
        eh = exp_hdr(widx, 2); w = mkword(eh, widx);
        n_cmp++; if (if_f.out_rd_data !== w[133:0]) begin n_bad++; $display("FAIL b2b_data: got %h want %h", if_f.out_rd_data, w[133:0]); end
        n_cmp++; if (if_f.out_rd_phv_wr !== (eh == HDR_HEAD)) begin n_bad++; $display("FAIL b2b_phv_wr: got %b want %b", if_f.out_rd_phv_wr, eh == HDR_HEAD); end
        if (eh == HDR_HEAD) begin
          ephv = '0; ephv[31:0] = 32'(heads);
          n_cmp++; if (if_f.out_rd_phv !== ephv) begin n_bad++; $display("FAIL b2b_seq: got %0d want %0d", if_f.out_rd_phv[31:0], heads); end
          if (last_head >= 0) begin
            n_cmp++; if (c - last_head !== 5) begin n_bad++; $display("FAIL b2b_spacing: got %0d want 5", c - last_head); end
          end
          last_head = c; heads++;
          if (heads == 3) start_f = 1'b0;
        end
        if (eh == HDR_TAIL) begin tail_cyc = c; widx = 0; end else widx++;
      end
      if (if_f.out_rd_valid_wr) begin
        nvalid++;
        n_cmp++; if (c !== tail_cyc + 1 || if_f.out_rd_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_valid: got cyc %0d valid %b want cyc %0d valid 1", c, if_f.out_rd_valid, tail_cyc + 1); end
      end
    end
    n_cmp++; if (heads !== 3 || nvalid !== 3) begin n_bad++; $display("FAIL b2b_count: got heads=%0d valids=%0d want 3/3", heads, nvalid); end
    n_cmp++; if (pkt_f !== 32'd3) begin n_bad++; $display("FAIL b2b_pkt_cnt: got %0d want 3", pkt_f); end
    n_cmp++; if (dut_f.state !== RD_IDLE) begin n_bad++; $display("FAIL b2b_idle: got %0d want IDLE", dut_f.state); end
  endtask

  task automatic test_token_rate();
    int heads, last_head;
    load_template(2);
    heads = 0; last_head = -1;
    @(negedge clk); start_s = 1'b1;
    for (int c = 0; c < 560; c++) begin
      @(negedge clk);
      if (if_s.out_rd_phv_wr) begin
        if (heads == 0) begin
          n_cmp++; if (c < 256 || c > 262) begin n_bad++; $display("FAIL rate_first_head: got cyc %0d want 256..262", c); end
        end else begin
          n_cmp++; if (c - last_head < 256 || c - last_head > 260) begin n_bad++; $display("FAIL rate_spacing: got %0d want 256..260", c - last_head); end
          start_s = 1'b0;
        end
        last_head = c; heads++;
      end
    end
    n_cmp++; if (heads !== 2 || pkt_s !== 32'd2) begin n_bad++; $display("FAIL rate_count: got heads=%0d pkt=%0d want 2/2", heads, pkt_s); end
  endtask

  task automatic test_finish_mid_packet();
    logic [143:0] w;
    int widx, nvalid, late_rd;
    logic done;
    load_template(4);
    widx = 0; nvalid = 0; late_rd = 0; done = 1'b0;
    @(negedge clk); start_f = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done && rd_en_f) late_rd++;
      if (if_f.out_rd_data_wr) begin
        w = mkword(exp_hdr(widx, 4), widx);
        n_cmp++; if (if_f.out_rd_data !== w[133:0]) begin n_bad++; $display("FAIL fin_data: got %h want %h", if_f.out_rd_data, w[133:0]); end
        widx++;
        if (widx == 2) fin_f = 1'b1;
      end
      if (if_f.out_rd_valid_wr) begin nvalid++; done = 1'b1; end
    end
    n_cmp++; if (widx !== 5 || nvalid !== 1) begin n_bad++; $display("FAIL fin_words: got words=%0d valids=%0d want 5/1", widx, nvalid); end
    n_cmp++; if (late_rd !== 0) begin n_bad++; $display("FAIL fin_rd_en: got %0d late reads want 0", late_rd); end
    n_cmp++; if (dut_f.state !== RD_IDLE || pkt_f !== 32'd1) begin n_bad++; $display("FAIL fin_idle: got state %0d pkt %0d want IDLE/1", dut_f.state, pkt_f); end
    start_f = 1'b0; fin_f = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_alf();
    int rd_cnt, rd_cyc, head_cyc;
    load_template(2);
    rd_cnt = 0; rd_cyc = -1; head_cyc = -1;
    @(negedge clk); if_f.in_rd_alf = 1'b1; start_f = 1'b1;
    repeat (40) begin @(negedge clk); if (rd_en_f) rd_cnt++; end
    if_f.in_rd_alf = 1'b0; if_f.in_rd_phv_alf = 1'b1;
    repeat (5) begin @(negedge clk); if (rd_en_f) rd_cnt++; end
    n_cmp++; if (rd_cnt !== 0) begin n_bad++; $display("FAIL alf_rd_en: got %0d reads want 0", rd_cnt); end
    n_cmp++; if (dut_f.u_bucket.tokens !== 16'd4096) begin n_bad++; $display("FAIL alf_tokens: got %0d want 4096", dut_f.u_bucket.tokens); end
    if_f.in_rd_phv_alf = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (rd_en_f && rd_cyc < 0) rd_cyc = c;
      if (if_f.out_rd_data_wr && if_f.out_rd_phv_wr && head_cyc < 0) head_cyc = c;
      if (c == 1) start_f = 1'b0;
    end
    n_cmp++; if (rd_cyc !== 0) begin n_bad++; $display("FAIL alf_release: got rd_en cyc %0d want 0", rd_cyc); end
    n_cmp++; if (head_cyc !== rd_cyc + 2) begin n_bad++; $display("FAIL alf_head_lat: got cyc %0d want %0d", head_cyc, rd_cyc + 2); end
    repeat (5) @(negedge clk);
  endtask

  task automatic test_no_tail();
    logic [143:0] w;
    int widx, nvalid, tail_cyc;
    logic ok_words;
    load_template(-1);
    widx = 0; nvalid = 0; tail_cyc = -10; ok_words = 1'b1;
    @(negedge clk); start_f = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (if_f.out_rd_data_wr) begin
        w = mkword(exp_hdr(widx, -1), widx);
        if (widx == 127) begin w[133:132] = HDR_TAIL; tail_cyc = c; end
        if (if_f.out_rd_data !== w[133:0]) begin
          if (ok_words) $display("FAIL trunc_word%0d: got %h want %h", widx, if_f.out_rd_data, w[133:0]);
          ok_words = 1'b0;
        end
        widx++;
        start_f = 1'b0;
      end
      if (if_f.out_rd_valid_wr) begin
        nvalid++;
        n_cmp++; if (c !== tail_cyc + 1) begin n_bad++; $display("FAIL trunc_valid: got cyc %0d want %0d", c, tail_cyc + 1); end
      end
    end
    n_cmp++; if (!ok_words) n_bad++;
    n_cmp++; if (widx !== 128 || nvalid !== 1) begin n_bad++; $display("FAIL trunc_count: got words=%0d valids=%0d want 128/1", widx, nvalid); end
    n_cmp++; if (err_f !== 16'd1 || pkt_f !== 32'd1) begin n_bad++; $display("FAIL trunc_cnt: got err=%0d pkt=%0d want 1/1", err_f, pkt_f); end
  endtask

  task automatic test_reset_mid_send();
    logic seen, stray;
    load_template(4);
    seen = 1'b0; stray = 1'b0;
    @(negedge clk); start_f = 1'b1;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (if_f.out_rd_phv_wr) seen = 1'b1;
    end
    n_cmp++; if (!seen) begin n_bad++; $display("FAIL rstsend_head: got no head want head within 20 cycles"); end
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++; if ({if_f.out_rd_data_wr, if_f.out_rd_phv_wr, if_f.out_rd_valid, if_f.out_rd_valid_wr, rd_en_f} !== 5'b0) begin n_bad++; $display("FAIL rstsend_strobes: got %b want 00000", {if_f.out_rd_data_wr, if_f.out_rd_phv_wr, if_f.out_rd_valid, if_f.out_rd_valid_wr, rd_en_f}); end
    n_cmp++; if (if_f.out_rd_data !== '0 || pkt_f !== 32'd0) begin n_bad++; $display("FAIL rstsend_data: got %h pkt %0d want 0", if_f.out_rd_data, pkt_f); end
    n_cmp++; if (dut_f.state !== RD_IDLE || dut_f.u_bucket.tokens !== 16'd0) begin n_bad++; $display("FAIL rstsend_state: got %0d tokens %0d want IDLE/0", dut_f.state, dut_f.u_bucket.tokens); end
    start_f = 1'b0; rst_n = 1'b1;
    byp_f = 1'b1;
    @(negedge clk); start_f = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (dut_f.state !== RD_IDLE || rd_en_f || if_f.out_rd_data_wr) stray = 1'b1;
    end
    n_cmp++; if (stray) begin n_bad++; $display("FAIL bypass_idle: got activity want IDLE"); end
    start_f = 1'b0; byp_f = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    byp_f = 1'b0; start_f = 1'b0; fin_f = 1'b0;
    byp_s = 1'b0; start_s = 1'b0; fin_s = 1'b0;
    if_f.in_rd_alf = 1'b0; if_f.in_rd_phv_alf = 1'b0;
    if_s.in_rd_alf = 1'b0; if_s.in_rd_phv_alf = 1'b0;
    load_template(2);
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    test_back_to_back();
    test_token_rate();
    test_finish_mid_packet();
    test_alf();
    test_no_tail();
    test_reset_mid_send();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
